// File: rtl/monitor_cluster_sched.sv
// monitor_cluster_sched: feeds a trace-symbol FIFO into an LTL monitor cluster,
// samples the cluster's violation flags one cycle after each issue, accumulates
// them into a sticky vector and raises one report per newly violated property.
// Issue stalls while a report is outstanding or a new hit is being sampled, so
// every new violation is reported on its own, in order.
module monitor_cluster_sched #(
  parameter int SYM_W   = 8,
  parameter int NUM_LTL = 10,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_symbol,
  output logic                     mon_run,
  output logic [SYM_W-1:0]         mon_symbols,
  output logic                     mon_reset,
  input  logic [NUM_LTL-1:0]       mon_flags,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [NUM_LTL-1:0]       rpt_mask,
  output logic [15:0]              rpt_seq,
  output logic [NUM_LTL-1:0]       sticky,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SYM_W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM_LTL-1:0]   sticky_q, sticky_d;
  logic [15:0]          seq_q, seq_d;
  logic                 sample_q, sample_d;
  logic [15:0]          sample_seq_q, sample_seq_d;
  logic                 rpt_valid_q, rpt_valid_d;
  logic [NUM_LTL-1:0]   rpt_mask_q, rpt_mask_d;
  logic [15:0]          rpt_seq_q, rpt_seq_d;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 issue_state;
  logic [NUM_LTL-1:0]   fresh;
  logic                 new_hit;

  // Handshake, issue decision and cluster-facing outputs; the flags-to-mon_run
  // path is deliberately combinational so a new hit blocks the very next issue.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    in_ready    = !reset && !full;
    push        = in_valid && in_ready;
    issue_state = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    fresh       = mon_flags & ~sticky_q;
    new_hit     = sample_q && (|fresh);
    mon_run     = !reset && issue_state && !empty && !rpt_valid_q && !new_hit;
    mon_symbols = mon_run ? mem_q[rd_ptr_q] : '0;
    mon_reset   = reset || (state_q == ST_CLEAR);
    rpt_valid   = rpt_valid_q;
    rpt_mask    = rpt_mask_q;
    rpt_seq     = rpt_seq_q;
    sticky      = sticky_q;
    busy        = (state_q != ST_IDLE);
    fifo_count  = count_q;
  end

  // Next-state computation for the session FSM, FIFO pointers, sticky vector,
  // sequence counter, sample stage and report register.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    sticky_d     = sticky_q;
    seq_d        = seq_q;
    sample_d     = mon_run;
    sample_seq_d = sample_seq_q;
    rpt_valid_d  = rpt_valid_q;
    rpt_mask_d   = rpt_mask_q;
    rpt_seq_d    = rpt_seq_q;

    if (reset) begin
      state_d      = ST_IDLE;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      sticky_d     = '0;
      seq_d        = '0;
      sample_d     = 1'b0;
      sample_seq_d = '0;
      rpt_valid_d  = 1'b0;
      rpt_mask_d   = '0;
      rpt_seq_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_RUN;
        ST_RUN:   if (stop) state_d = ST_DRAIN;
        ST_DRAIN: if (empty && !sample_q && !rpt_valid_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (mon_run) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(mon_run);

      // A new session starts from a clean sticky vector and sequence 0, so
      // both are already zero while the cluster is held in reset by CLEAR.
      if ((state_q == ST_IDLE) && start) begin
        sticky_d = '0;
        seq_d    = '0;
      end else begin
        if (sample_q) sticky_d = sticky_q | mon_flags;
        if (mon_run)  seq_d    = seq_q + 16'd1;
      end

      if (mon_run) sample_seq_d = seq_q;

      // The report mask uses the pre-update sticky so only newly set flags show.
      if (new_hit) begin
        rpt_valid_d = 1'b1;
        rpt_mask_d  = fresh;
        rpt_seq_d   = sample_seq_q;
      end else if (rpt_valid_q && rpt_ready) begin
        rpt_valid_d = 1'b0;
      end
    end
  end

  // FIFO storage: written only on an accepted symbol, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_symbol;
  end

  // State registers; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    rd_ptr_q     <= rd_ptr_d;
    wr_ptr_q     <= wr_ptr_d;
    count_q      <= count_d;
    sticky_q     <= sticky_d;
    seq_q        <= seq_d;
    sample_q     <= sample_d;
    sample_seq_q <= sample_seq_d;
    rpt_valid_q  <= rpt_valid_d;
    rpt_mask_q   <= rpt_mask_d;
    rpt_seq_q    <= rpt_seq_d;
  end

endmodule

// File: doc/monitor_cluster_sched.md
MONITOR_CLUSTER_SCHED -- requirements
Module: monitor_cluster_sched

Interface
REQ-001 SHALL have parameter SYM_W, default 8, width of one trace symbol.
REQ-002 SHALL have parameter NUM_LTL, default 10, number of LTL violation flags from the cluster.
REQ-003 SHALL have parameter DEPTH, default 8, symbol FIFO depth, power of two.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a monitoring session.
REQ-007 SHALL have port stop  input  1  one-cycle pulse that ends a session after draining.
REQ-008 SHALL have ports in_valid/in_ready/in_symbol  input/output/input  1/1/SYM_W  trace symbol stream; transfer when both valid and ready are high.
REQ-009 SHALL have ports mon_run/mon_symbols/mon_reset  output  1/SYM_W/1  drive the cluster's run, symbols and reset inputs.
REQ-010 SHALL have port mon_flags  input  NUM_LTL  cluster violation outputs, one per LTL property.
REQ-011 SHALL have ports rpt_valid/rpt_ready/rpt_mask/rpt_seq  output/input/output/output  1/1/NUM_LTL/16  violation report handshake.
REQ-012 SHALL have port sticky  output  NUM_LTL  accumulated violations of the current session.
REQ-013 SHALL have ports busy/fifo_count  output  1/log2(DEPTH)+1  busy = state != IDLE; fifo_count = FIFO occupancy.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, RUN and DRAIN.
REQ-015 IDLE: start -> CLEAR; stop ignored. start is ignored in every state except IDLE.
REQ-016 CLEAR SHALL last exactly 1 cycle with mon_reset=1, sticky cleared to 0 and seq cleared to 0, then go to RUN.
REQ-017 RUN: stop -> DRAIN; issue continues.
REQ-018 DRAIN SHALL go to IDLE in the first cycle where the FIFO is empty, no sample is pending and rpt_valid=0.
REQ-019 FIFO SHALL accept input in every state; in_ready = !full, based on the registered count. There is no push when full, even with a same-cycle pop.
REQ-020 FIFO SHALL have no bypass: a symbol accepted in cycle t reaches mon_run=1 no earlier than cycle t+1.
REQ-021 Issue rule: mon_run = (state RUN or DRAIN) & !empty & !rpt_valid & !new_hit. The path from mon_flags to mon_run through new_hit SHALL be combinational.
REQ-022 When mon_run=1, mon_symbols SHALL be the FIFO head and that entry SHALL pop that cycle; when mon_run=0, mon_symbols=0.
REQ-023 Cluster flags for a symbol issued in cycle t SHALL be sampled in cycle t+1 (sample = registered mon_run).
REQ-024 new_hit = sample & |(mon_flags & ~sticky).
REQ-025 Every sample cycle SHALL perform sticky |= mon_flags.
REQ-026 On new_hit: rpt_valid=1 next cycle; rpt_mask = mon_flags & ~sticky (pre-update value); rpt_seq = sequence number of the sampled symbol.
REQ-027 rpt_valid SHALL hold with rpt_mask and rpt_seq stable until rpt_ready=1, and clear the cycle after acceptance.
REQ-028 Because issue is stalled by REQ-021, no violation SHALL be lost or merged.
REQ-029 seq SHALL be a 16-bit counter of issued symbols: first symbol of a session = 0, incremented per issue, wrapping 0xFFFF -> 0.
REQ-030 Flags that are already sticky SHALL never generate a report.
REQ-031 mon_reset = reset | (state == CLEAR).

Reset
REQ-032 reset SHALL force, at the next edge: state=IDLE, FIFO empty (contents discarded), sticky=0, seq=0, rpt_valid=0, rpt_mask=0, rpt_seq=0, sample=0.
REQ-033 While reset=1: mon_run=0, mon_reset=1, in_ready=0.
REQ-034 reset mid-session SHALL drop any pending report and queued symbols, with no further outputs.

Verification
REQ-035 Reset, start, push 0x11,0x22,0x33, flags=0 -> mon_reset high 1 cycle; mon_run issues 0x11,0x22,0x33 in order; rpt_valid never 1; sticky=0.
REQ-036 Flags=0x004 sampled for the 2nd symbol -> rpt_mask=0x004, rpt_seq=1, sticky=0x004; later flags=0x004 -> no report; flags=0x005 -> rpt_mask=0x001.
REQ-037 Hold rpt_ready=0 for 5 cycles after a report while pushing -> mon_run=0 throughout; fifo_count reaches 8, in_ready=0; issue resumes the cycle after acceptance.
REQ-038 stop with 4 symbols queued -> all 4 issued in DRAIN; busy falls the cycle after the last sample if there is no report, otherwise after the report is accepted.
REQ-039 reset in RUN with 5 queued and rpt_valid=1 -> next cycle fifo_count=0, rpt_valid=0, busy=0; mon_reset=1 while reset is high.
REQ-040 Issue 65537 symbols with violation on the last -> rpt_seq=0x0000 (wrap).
